// File: rtl/fork_nway_pkg.sv
// Shared types and constants for the N-way Avalon-ST packet fork.
package fork_nway_pkg;

  localparam int STATS_W = 32;
  localparam int CHAN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  // Width of the Avalon-ST empty field for a given data width; never below 1 bit.
  function automatic int empty_w(input int width);
    return (width > 8) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/fork_nway_avlstrm_if.sv
// Avalon-ST packet stream bundle shared by the fork input and every output.
interface avl_stream_if
  import fork_nway_pkg::*;
#(
  parameter int WIDTH = 512
);
  localparam int EMPTY_W = empty_w(WIDTH);

  // A beat transfers on a clock edge where valid and ready are both high.
  // The source holds valid and all payload fields stable until that edge.
  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic [CHAN_W-1:0]  channel;

  modport tx (output data, valid, sop, eop, empty, channel, input ready);
  modport rx (input data, valid, sop, eop, empty, channel, output ready);

endinterface

// File: rtl/fork_nway_fifo.sv
// Synchronous FIFO with flop storage, registered fill/valid and no fall-through.
module fork_nway_fifo #(
  parameter type T      = logic,
  parameter int  DEPTH  = 8,
  localparam int FILL_W = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  T                  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output T                  rd_data,
  output logic [FILL_W-1:0] fill
);

  T                  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] cnt_q, cnt_d;
  logic              full, do_wr, do_rd;

  always_comb begin
    full     = (cnt_q == FILL_W'(DEPTH));
    rd_valid = (cnt_q != '0);
    do_wr    = wr_en & ~full;
    do_rd    = rd_valid & rd_ready;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    cnt_d    = cnt_q + FILL_W'(do_wr) - FILL_W'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign fill    = cnt_q;

endmodule

// File: rtl/fork_nway_avlstrm.sv
// N-way Avalon-ST packet fork steered by channel at SOP; out-of-range packets are dropped.
// Statistics counters exist only when FORK_NWAY_STATS_EN is defined.
module fork_nway_avlstrm
  import fork_nway_pkg::*;
#(
  parameter int NUM_OUT    = 2,
  parameter int WIDTH      = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  avl_stream_if.rx            in,
  avl_stream_if.tx            out [NUM_OUT],
  output logic [STATS_W-1:0]  stats_pkt [NUM_OUT],
  output logic [STATS_W-1:0]  stats_drop_pkt,
  output logic [STATS_W-1:0]  stats_err_beat,
  output logic [STATS_W-1:0]  max_fill [NUM_OUT],
  output state_e              dbg_state
);

  localparam int EMPTY_W = empty_w(WIDTH);
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int FILL_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [CHAN_W-1:0]  channel;
  } entry_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   dest_q, dest_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ok;
  logic               ready, accept;
  logic [NUM_OUT-1:0] full, push;
  logic [FILL_W-1:0]  fill [NUM_OUT];
  entry_t             wr_entry;

  assign sel_ok  = (in.channel < CHAN_W'(NUM_OUT));
  assign sel_idx = in.channel[IDX_W-1:0];

  // Ready looks only at state, channel and registered full flags, never at valid.
  always_comb begin
    case (state_q)
      IDLE:    ready = sel_ok ? ~full[sel_idx] : 1'b1;
      FWD:     ready = ~full[dest_q];
      DROP:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (Rst) ready = 1'b0;
  end

  assign in.ready = ready;
  assign accept   = in.valid & ready;
  assign wr_entry = '{data: in.data, sop: in.sop, eop: in.eop,
                      empty: in.empty, channel: in.channel};

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    push    = '0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in.sop && sel_ok) begin
            push[sel_idx] = 1'b1;
            if (!in.eop) begin
              state_d = FWD;
              dest_d  = sel_idx;
            end
          end else if (in.sop && !in.eop) begin
            state_d = DROP;
          end
        end
        FWD: begin
          // A stray SOP mid-packet still follows the latched destination.
          push[dest_q] = 1'b1;
          if (in.eop) state_d = IDLE;
        end
        DROP:    if (in.eop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  assign dbg_state = state_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    entry_t rd_entry;
    logic   rd_valid;

    fork_nway_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (Clk),
      .rst      (Rst),
      .wr_en    (push[g]),
      .wr_data  (wr_entry),
      .rd_valid (rd_valid),
      .rd_ready (out[g].ready),
      .rd_data  (rd_entry),
      .fill     (fill[g])
    );

    assign full[g]        = (fill[g] == FILL_W'(FIFO_DEPTH));
    assign out[g].valid   = rd_valid;
    assign out[g].data    = rd_entry.data;
    assign out[g].sop     = rd_entry.sop;
    assign out[g].eop     = rd_entry.eop;
    assign out[g].empty   = rd_entry.empty;
    assign out[g].channel = rd_entry.channel;
  end

`ifdef FORK_NWAY_STATS_EN
  logic               err_beat, drop_end;
  logic [STATS_W-1:0] pkt_q [NUM_OUT];
  logic [STATS_W-1:0] pkt_d [NUM_OUT];
  logic [STATS_W-1:0] mf_q  [NUM_OUT];
  logic [STATS_W-1:0] mf_d  [NUM_OUT];
  logic [STATS_W-1:0] drop_q, drop_d, err_q, err_d;

  always_comb begin
    err_beat = accept & (((state_q == IDLE) & ~in.sop) | ((state_q == FWD) & in.sop));
    drop_end = accept & in.eop &
               (((state_q == IDLE) & in.sop & ~sel_ok) | (state_q == DROP));
    drop_d   = drop_q + STATS_W'(drop_end);
    err_d    = err_q + STATS_W'(err_beat);
    for (int i = 0; i < NUM_OUT; i++) begin
      pkt_d[i] = pkt_q[i] + STATS_W'(push[i] & in.eop);
      mf_d[i]  = (STATS_W'(fill[i]) > mf_q[i]) ? STATS_W'(fill[i]) : mf_q[i];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      drop_q <= '0;
      err_q  <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        pkt_q[i] <= '0;
        mf_q[i]  <= '0;
      end
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_OUT; i++) begin
        pkt_q[i] <= pkt_d[i];
        mf_q[i]  <= mf_d[i];
      end
    end
  end

  assign stats_pkt      = pkt_q;
  assign max_fill       = mf_q;
  assign stats_drop_pkt = drop_q;
  assign stats_err_beat = err_q;
`else
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      stats_pkt[i] = '0;
      max_fill[i]  = '0;
    end
  end

  assign stats_drop_pkt = '0;
  assign stats_err_beat = '0;
`endif

endmodule

// File: tb/tb_fork_nway_avlstrm.sv
// Randomised and directed bench for fork_nway_avlstrm with a packet-level reference model.
module tb_fork_nway_avlstrm;
  import fork_nway_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int EW = 2;
  localparam int BW = W + 2 + EW + CHAN_W;
`ifdef FORK_NWAY_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  avl_stream_if #(.WIDTH(W)) in_if ();
  avl_stream_if #(.WIDTH(W)) out_if [N] ();

  logic [31:0] s_pkt [N];
  logic [31:0] s_mf  [N];
  logic [31:0] s_drop, s_err;
  state_e      dbg_state;

  fork_nway_avlstrm #(.NUM_OUT(N), .WIDTH(W), .FIFO_DEPTH(D)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .in             (in_if),
    .out            (out_if),
    .stats_pkt      (s_pkt),
    .stats_drop_pkt (s_drop),
    .stats_err_beat (s_err),
    .max_fill       (s_mf),
    .dbg_state      (dbg_state)
  );

  logic              in_valid, in_sop, in_eop, in_ready;
  logic [W-1:0]      in_data;
  logic [EW-1:0]     in_empty;
  logic [CHAN_W-1:0] in_ch;
  logic [N-1:0]      out_rdy, hold_rdy, o_valid;
  logic [BW-1:0]     o_beat [N];

  assign in_if.valid   = in_valid;
  assign in_if.sop     = in_sop;
  assign in_if.eop     = in_eop;
  assign in_if.data    = in_data;
  assign in_if.empty   = in_empty;
  assign in_if.channel = in_ch;
  assign in_ready      = in_if.ready;

  for (genvar g = 0; g < N; g++) begin : g_mon
    assign out_if[g].ready = out_rdy[g];
    assign o_valid[g]      = out_if[g].valid;
    assign o_beat[g]       = {out_if[g].data, out_if[g].sop, out_if[g].eop,
                              out_if[g].empty, out_if[g].channel};
  end

  // ---------------- scoreboard / model ----------------
  logic [BW-1:0] exp_q [N][$];
  int            exp_t [N][$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            rnd_mode = 1'b0;
  bit            lat_chk = 1'b0;
  bit            last_acc = 1'b0;
  bit            m_busy, m_drop;
  int            m_dest, m_drop_cnt, m_err;
  int            m_pkt [N];
  int            steer_pkt [N] = '{1, 0, 1, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      exp_t[i].delete();
      m_pkt[i] = 0;
    end
    m_busy = 0; m_drop = 0; m_dest = 0; m_drop_cnt = 0; m_err = 0;
  endtask

  task automatic exp_push(input int ch, input logic [BW-1:0] b);
    exp_q[ch].push_back(b);
    exp_t[ch].push_back(cyc);
  endtask

  // Packet rules: steer by SOP channel, drop out-of-range, count framing errors.
  task automatic model_accept();
    logic [BW-1:0] b;
    b = {in_data, in_sop, in_eop, in_empty, in_ch};
    if (!m_busy) begin
      if (!in_sop) m_err++;
      else if (int'(in_ch) < N) begin
        exp_push(int'(in_ch), b);
        if (in_eop) m_pkt[in_ch]++;
        else begin m_busy = 1; m_drop = 0; m_dest = int'(in_ch); end
      end else if (in_eop) m_drop_cnt++;
      else begin m_busy = 1; m_drop = 1; end
    end else if (m_drop) begin
      if (in_eop) begin m_drop_cnt++; m_busy = 0; end
    end else begin
      if (in_sop) m_err++;
      exp_push(m_dest, b);
      if (in_eop) begin m_pkt[m_dest]++; m_busy = 0; end
    end
  endtask

  task automatic sample();
    int t;
    last_acc = in_valid && in_ready;
    if (last_acc) model_accept();
    for (int i = 0; i < N; i++) begin
      if (o_valid[i] && out_rdy[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("out%0d_extra_beat", i), 64'(1), 64'(0));
        end else begin
          check($sformatf("out%0d_beat", i), 64'(o_beat[i]), 64'(exp_q[i].pop_front()));
          t = exp_t[i].pop_front();
          if (lat_chk) check($sformatf("out%0d_latency", i), 64'(cyc), 64'(t + 1));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    sample();
    @(posedge Clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      out_rdy[i] = rnd_mode ? ($urandom_range(0, 3) != 0) : hold_rdy[i];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input int ch, input bit sop, input bit eop, output int waits);
    in_valid = 1'b1;
    in_ch    = CHAN_W'(ch);
    in_sop   = sop;
    in_eop   = eop;
    in_data  = $urandom;
    in_empty = eop ? EW'($urandom_range(0, 3)) : '0;
    waits    = 0;
    do begin
      tick();
      waits++;
    end while (!last_acc && waits < 300);
    if (!last_acc) check("in_ready_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int len, output int worst);
    int w;
    worst = 0;
    for (int k = 0; k < len; k++) begin
      send_beat(ch, k == 0, k == len - 1, w);
      if (w > worst) worst = w;
    end
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_stats_pkt%0d", tag, i), 64'(s_pkt[i]), 64'(STATS_ON ? m_pkt[i] : 0));
    check({tag, "_stats_drop"}, 64'(s_drop), 64'(STATS_ON ? m_drop_cnt : 0));
    check({tag, "_stats_err"}, 64'(s_err), 64'(STATS_ON ? m_err : 0));
  endtask

  task automatic check_drained(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_drained%0d", tag, i), 64'(exp_q[i].size()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w, worst, ch, len;
    in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; in_empty = '0; in_ch = '0;
    hold_rdy = '1;
    out_rdy  = '1;
    model_reset();

    // Reset state
    Rst = 1'b1;
    idle(2);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(o_valid), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check_stats("rst");
    Rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Steering: 3-beat packets on ch 0, 2, 3 with all outputs ready
    lat_chk = 1'b1;
    send_pkt(0, 3, worst);
    check("steer_rate", 64'(worst), 64'(1));
    send_pkt(2, 3, worst);
    send_pkt(3, 3, worst);
    idle(3);
    lat_chk = 1'b0;
    check_drained("steer");
    for (int i = 0; i < N; i++) begin
      check($sformatf("steer_pkt%0d", i), 64'(s_pkt[i]), 64'(STATS_ON ? steer_pkt[i] : 0));
      check($sformatf("steer_max_fill%0d", i), 64'(s_mf[i]), 64'(STATS_ON ? steer_pkt[i] : 0));
    end

    // Drop: 4-beat packet on out-of-range ch 5
    send_pkt(5, 4, worst);
    check("drop_rate", 64'(worst), 64'(1));
    idle(2);
    check("drop_cnt", 64'(s_drop), 64'(STATS_ON ? 1 : 0));

    // Backpressure: out[1] stalled, 10-beat packet to ch 1
    hold_rdy[1] = 1'b0;
    tick();
    worst = 0;
    for (int k = 0; k < 8; k++) begin
      send_beat(1, k == 0, 1'b0, w);
      if (w > worst) worst = w;
    end
    check("bp_fill_rate", 64'(worst), 64'(1));
    in_valid = 1'b1; in_ch = 8'd1; in_sop = 1'b0; in_eop = 1'b0; in_data = $urandom;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_stall", 64'(last_acc), 64'(0));
    end
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_other_out_idle", 64'(o_valid[0]), 64'(0));
    check("bp_max_fill", 64'(s_mf[1]), 64'(STATS_ON ? D : 0));
    in_valid = 1'b0;
    hold_rdy[1] = 1'b1;
    send_beat(1, 1'b0, 1'b0, w);
    send_beat(1, 1'b0, 1'b1, w);
    send_pkt(0, 2, worst);
    idle(12);
    check_drained("bp");

    // Framing: stray non-SOP in IDLE, then SOP mid-packet with a different channel
    send_beat(0, 1'b0, 1'b1, w);
    idle(2);
    check("frame_err1", 64'(s_err), 64'(STATS_ON ? 1 : 0));
    send_beat(3, 1'b1, 1'b0, w);
    send_beat(1, 1'b1, 1'b0, w);
    send_beat(3, 1'b0, 1'b1, w);
    idle(3);
    check("frame_err2", 64'(s_err), 64'(STATS_ON ? 2 : 0));
    check("frame_dest_kept", 64'(s_pkt[3]), 64'(STATS_ON ? 2 : 0));
    check_drained("frame");

    // Reset mid-packet: beat 1 of 4 parked in FIFO 2, reset while beat 2 is offered
    hold_rdy[2] = 1'b0;
    tick();
    send_beat(2, 1'b1, 1'b0, w);
    in_valid = 1'b1; in_ch = 8'd2; in_sop = 1'b0; in_eop = 1'b0;
    Rst = 1'b1;
    model_reset();
    #1;
    check("midrst_out_valid", 64'(o_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    for (int i = 0; i < N; i++)
      check($sformatf("midrst_max_fill%0d", i), 64'(s_mf[i]), 64'(0));
    check_stats("midrst");
    tick();
    in_valid = 1'b0;
    Rst = 1'b0;
    hold_rdy[2] = 1'b1;
    tick();
    send_pkt(2, 2, worst);
    idle(3);
    check("midrst_new_pkt", 64'(s_pkt[2]), 64'(STATS_ON ? 1 : 0));
    check_drained("midrst");

    // Random traffic with random output backpressure
    rnd_mode = 1'b1;
    for (int p = 0; p < 150; p++) begin
      ch = $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) begin
        send_beat(ch, 1'b0, $urandom_range(0, 1) == 1, w);
      end else begin
        len = $urandom_range(1, 5);
        send_pkt(ch, len, worst);
      end
    end
    rnd_mode = 1'b0;
    hold_rdy = '1;
    idle(20);
    check_drained("rnd");
    check_stats("rnd");
    for (int i = 0; i < N; i++)
      check($sformatf("rnd_max_fill_bound%0d", i), 64'(s_mf[i] <= D), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
